// File: rtl/axi_wr_stream_checker.sv
// Passive AXI write-channel checker: tracks AW bursts, compares accepted W beats
// against an external expected-data memory and reports counts and a verdict.
//
// state   | meaning
// S_IDLE  | after reset, handshakes ignored until start
// S_ARMED | run active, AW/W beats tracked and compared
// S_DONE  | all cfg_words beats compared, verdict held until next start
`timescale 1ns/1ps
module axi_wr_stream_checker #(
  parameter int A         = 32,
  parameter int D         = 32,
  parameter int L         = 8,
  parameter int EXP_AW    = 16,
  parameter int OST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [A-1:0]      cfg_base,
  input  logic [EXP_AW:0]   cfg_words,
  input  logic              AWVALID,
  input  logic              AWREADY,
  input  logic [A-1:0]      AWADDR,
  input  logic [L-1:0]      AWLEN,
  input  logic              WVALID,
  input  logic              WREADY,
  input  logic [D-1:0]      WDATA,
  input  logic [D/8-1:0]    WSTRB,
  input  logic              WLAST,
  output logic              exp_rd_en,
  output logic [EXP_AW-1:0] exp_rd_addr,
  input  logic [D-1:0]      exp_rd_data,
  output logic [EXP_AW:0]   beat_cnt,
  output logic [EXP_AW:0]   err_cnt,
  output logic              proto_err,
  output logic              first_err_valid,
  output logic [EXP_AW-1:0] first_err_idx,
  output logic [D-1:0]      first_err_got,
  output logic [D-1:0]      first_err_exp,
  output logic              done,
  output logic              pass
);

  localparam int SB = D / 8;
  localparam int BL = (SB > 1) ? $clog2(SB) : 0;
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = EXP_AW + 1;
  localparam logic [A-1:0] ALIGN_MASK = A'(SB - 1);
  localparam logic [PW:0]  DEPTH_C    = (PW + 1)'(OST_DEPTH);
  localparam logic [PW:0]  CNT_ONE    = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;
  state_t state;

  logic [A-1:0]      base_q;
  logic [CW-1:0]     words_q;
  logic [EXP_AW-1:0] fifo_idx [OST_DEPTH];
  logic [L-1:0]      fifo_len [OST_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       fifo_cnt;
  logic [L-1:0]      beat_off;
  logic [CW-1:0]     issue_cnt;

  logic              cmp_valid;
  logic [D-1:0]      cmp_data;
  logic [SB-1:0]     cmp_strb;
  logic [EXP_AW-1:0] cmp_idx;

  logic armed, aw_hs, w_hs, fifo_empty, head_last, w_ok, pop, extra, issue;
  logic full_after_pop, push, aw_bad, proto_set, mism;
  logic [EXP_AW-1:0] head_idx, aw_idx;
  logic [L-1:0]      head_len;
  logic [A-1:0]      aw_off;

  always_comb begin
    armed          = (state == S_ARMED) && !start;
    aw_hs          = armed && AWVALID && AWREADY;
    w_hs           = armed && WVALID && WREADY;
    fifo_empty     = (fifo_cnt == '0);
    head_idx       = fifo_idx[rd_ptr];
    head_len       = fifo_len[rd_ptr];
    head_last      = (beat_off == head_len);
    w_ok           = w_hs && !fifo_empty;
    pop            = w_ok && head_last;
    extra          = (issue_cnt == words_q);
    issue          = w_ok && !extra;
    // Occupancy after this cycle's pop decides whether the AW entry fits.
    full_after_pop = (fifo_cnt == DEPTH_C) && !pop;
    push           = aw_hs && !full_after_pop;
    aw_off         = AWADDR - base_q;
    aw_idx         = EXP_AW'(aw_off >> BL);
    aw_bad         = (AWADDR < base_q) || ((AWADDR & ALIGN_MASK) != '0);
    proto_set      = (aw_hs && (full_after_pop || aw_bad))
                   || (w_hs && fifo_empty)
                   || (w_ok && ((WLAST != head_last) || extra));
    exp_rd_en      = issue;
    exp_rd_addr    = issue ? (head_idx + EXP_AW'(beat_off)) : '0;
  end

  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < SB; i++) begin
      if (cmp_strb[i] && (cmp_data[i*8 +: 8] != exp_rd_data[i*8 +: 8])) mism = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state           <= rst ? S_IDLE : S_ARMED;
      base_q          <= rst ? '0 : cfg_base;
      words_q         <= rst ? '0 : cfg_words;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      beat_off        <= '0;
      issue_cnt       <= '0;
      cmp_valid       <= 1'b0;
      cmp_data        <= '0;
      cmp_strb        <= '0;
      cmp_idx         <= '0;
      beat_cnt        <= '0;
      err_cnt         <= '0;
      proto_err       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        S_ARMED: begin
          if (push) begin
            fifo_idx[wr_ptr] <= aw_idx;
            fifo_len[wr_ptr] <= AWLEN;
            wr_ptr           <= wr_ptr + PTR_ONE;
          end
          if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
          else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_ONE;

          if (w_ok) begin
            if (head_last) begin
              beat_off <= '0;
              rd_ptr   <= rd_ptr + PTR_ONE;
            end else begin
              beat_off <= beat_off + L'(1);
            end
          end
          if (proto_set) proto_err <= 1'b1;

          cmp_valid <= issue;
          if (issue) begin
            cmp_data  <= WDATA;
            cmp_strb  <= WSTRB;
            cmp_idx   <= exp_rd_addr;
            issue_cnt <= issue_cnt + CW'(1);
          end

          if (cmp_valid) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (mism) begin
              if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= cmp_idx;
                first_err_got   <= cmp_data;
                first_err_exp   <= exp_rd_data;
              end
            end
          end else if (beat_cnt == words_q) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !proto_err && !proto_set;
          end
        end
        S_IDLE, S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_stream_checker.sv
// Bench for axi_wr_stream_checker: table of single-burst runs plus hand-written
// sequences for FIFO overflow, WLAST/empty-FIFO errors and restart mid-burst.
`timescale 1ns/1ps
module tb_axi_wr_stream_checker;
  localparam int A = 32, D = 32, L = 8, EXP_AW = 16, OST = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [A-1:0] cfg_base = '0;
  logic [EXP_AW:0] cfg_words = '0;
  logic AWVALID = 1'b0, AWREADY = 1'b1, WVALID = 1'b0, WREADY = 1'b1, WLAST = 1'b0;
  logic [A-1:0] AWADDR = '0;
  logic [L-1:0] AWLEN = '0;
  logic [D-1:0] WDATA = '0;
  logic [D/8-1:0] WSTRB = '0;
  logic exp_rd_en, proto_err, first_err_valid, done, pass;
  logic [EXP_AW-1:0] exp_rd_addr, first_err_idx;
  logic [D-1:0] exp_rd_data = '0, first_err_got, first_err_exp;
  logic [EXP_AW:0] beat_cnt, err_cnt;

  always #5 clk = ~clk;

  axi_wr_stream_checker #(.A(A), .D(D), .L(L), .EXP_AW(EXP_AW), .OST_DEPTH(OST)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_words(cfg_words),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .exp_rd_en(exp_rd_en), .exp_rd_addr(exp_rd_addr), .exp_rd_data(exp_rd_data),
    .beat_cnt(beat_cnt), .err_cnt(err_cnt), .proto_err(proto_err),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .done(done), .pass(pass)
  );

  // Expected-data memory contents; index 5 holds 0x12345678.
  function automatic logic [31:0] mem_val(input logic [15:0] i);
    return 32'h1234_5678 ^ (32'(i ^ 16'd5) * 32'h0001_0103);
  endfunction

  always @(posedge clk) if (exp_rd_en) exp_rd_data <= mem_val(exp_rd_addr);

  int n_vec = 0, n_bad = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_rd_en) begin
      if (sb_q.size() == 0) check("spurious exp_rd_en", 64'(exp_rd_en), 64'd0);
      else check("exp_rd_addr", 64'(exp_rd_addr), 64'(sb_q.pop_front()));
    end
  end

  task automatic do_start(input logic [31:0] base, input int words);
    start = 1'b1; cfg_base = base; cfg_words = 17'(words);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] addr, input int len);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = 8'(len);
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                      input bit expect_rd, input logic [15:0] idx);
    if (expect_rd) sb_q.push_back(idx);
    WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("done", 64'(done), 64'd1);
  endtask

  typedef struct {
    int base_idx; int words; int bad1; int bad2;
    logic [31:0] xor1; logic [3:0] bad_strb;
    int exp_err; int exp_first; bit exp_pass;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0,   8, -1, -1, 32'h0, 4'hF, 0, 0, 1'b1};
    vecs[1] = '{0,   8,  5,  6, 32'h1234_5678 ^ 32'hDEAD_BEEF, 4'hF, 2, 5, 1'b0};
    vecs[2] = '{0,   4,  2, -1, 32'hFF00_0000, 4'b0011, 0, 0, 1'b1};
    vecs[3] = '{0,   4,  2, -1, 32'h0000_0001, 4'b0011, 1, 2, 1'b0};
    vecs[4] = '{16,  4,  0, -1, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1'b1};
    vecs[5] = '{100, 1, -1, -1, 32'h0, 4'hF, 0, 0, 1'b1};
    vecs[6] = '{0,   0, -1, -1, 32'h0, 4'hF, 0, 0, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset done", 64'(done), 64'd0);
    check("reset pass", 64'(pass), 64'd0);
    check("reset beat_cnt", 64'(beat_cnt), 64'd0);
    check("reset err_cnt", 64'(err_cnt), 64'd0);
    check("reset proto_err", 64'(proto_err), 64'd0);
    check("reset first_err_valid", 64'(first_err_valid), 64'd0);
    check("reset exp_rd_addr", 64'(exp_rd_addr), 64'd0);
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      do_start(BASE, vecs[v].words);
      if (vecs[v].words > 0) do_aw(BASE + 32'(vecs[v].base_idx * 4), vecs[v].words - 1);
      for (int b = 0; b < vecs[v].words; b++) begin
        logic [15:0] idx;
        logic [31:0] d;
        logic [3:0] s;
        idx = 16'(vecs[v].base_idx + b);
        d = mem_val(idx);
        s = 4'hF;
        if (b == vecs[v].bad1 || b == vecs[v].bad2) begin
          d = d ^ vecs[v].xor1;
          s = vecs[v].bad_strb;
        end
        do_w(d, s, b == vecs[v].words - 1, 1'b1, idx);
      end
      wait_done();
      check($sformatf("v%0d beat_cnt", v), 64'(beat_cnt), 64'(vecs[v].words));
      check($sformatf("v%0d err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      check($sformatf("v%0d first_err_valid", v), 64'(first_err_valid), 64'(vecs[v].exp_err > 0));
      check($sformatf("v%0d proto_err", v), 64'(proto_err), 64'd0);
      check($sformatf("v%0d pass", v), 64'(pass), 64'(vecs[v].exp_pass));
      if (vecs[v].exp_err > 0) begin
        logic [15:0] fi;
        fi = 16'(vecs[v].base_idx + vecs[v].exp_first);
        check($sformatf("v%0d first_err_idx", v), 64'(first_err_idx), 64'(fi));
        check($sformatf("v%0d first_err_exp", v), 64'(first_err_exp), 64'(mem_val(fi)));
        check($sformatf("v%0d first_err_got", v), 64'(first_err_got), 64'(mem_val(fi) ^ vecs[v].xor1));
      end
      @(posedge clk); #1;
    end

    // W beat while DONE is ignored
    do_w(32'h0, 4'hF, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    check("done ignores W proto_err", 64'(proto_err), 64'd0);
    check("done ignores W beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1;

    // AW FIFO overflow: fifth burst is dropped
    do_start(BASE, 4);
    for (int i = 0; i < 4; i++) do_aw(BASE + 32'(i * 4), 0);
    @(negedge clk);
    check("ovf proto_err after 4 AW", 64'(proto_err), 64'd0);
    @(posedge clk); #1;
    do_aw(BASE + 32'd16, 0);
    @(negedge clk);
    check("ovf proto_err after 5th AW", 64'(proto_err), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_w(mem_val(16'(i)), 4'hF, 1'b1, 1'b1, 16'(i));
    wait_done();
    check("ovf beat_cnt", 64'(beat_cnt), 64'd4);
    check("ovf err_cnt", 64'(err_cnt), 64'd0);
    check("ovf pass", 64'(pass), 64'd0);
    @(posedge clk); #1;

    // Early WLAST inside a 4-beat burst
    do_start(BASE, 4);
    do_aw(BASE, 3);
    do_w(mem_val(16'd0), 4'hF, 1'b0, 1'b1, 16'd0);
    do_w(mem_val(16'd1), 4'hF, 1'b0, 1'b1, 16'd1);
    @(negedge clk);
    check("wlast proto_err before", 64'(proto_err), 64'd0);
    @(posedge clk); #1;
    do_w(mem_val(16'd2), 4'hF, 1'b1, 1'b1, 16'd2);
    @(negedge clk);
    check("wlast proto_err early", 64'(proto_err), 64'd1);
    @(posedge clk); #1;
    do_w(mem_val(16'd3), 4'hF, 1'b1, 1'b1, 16'd3);
    wait_done();
    check("wlast beat_cnt", 64'(beat_cnt), 64'd4);
    check("wlast pass", 64'(pass), 64'd0);
    @(posedge clk); #1;

    // W with no outstanding AW
    do_start(BASE, 2);
    do_w(32'h1, 4'hF, 1'b1, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check("empty proto_err", 64'(proto_err), 64'd1);
    check("empty beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1;
    do_aw(BASE, 1);
    do_w(mem_val(16'd0), 4'hF, 1'b0, 1'b1, 16'd0);
    do_w(mem_val(16'd1), 4'hF, 1'b1, 1'b1, 16'd1);
    wait_done();
    check("empty beat_cnt final", 64'(beat_cnt), 64'd2);
    check("empty pass", 64'(pass), 64'd0);
    @(posedge clk); #1;

    // Restart mid-burst: start coincides with beat 3 of an 8-beat burst
    do_start(BASE, 8);
    do_aw(BASE, 7);
    do_w(mem_val(16'd0), 4'hF, 1'b0, 1'b1, 16'd0);
    do_w(mem_val(16'd1) ^ 32'h55, 4'hF, 1'b0, 1'b1, 16'd1);
    do_w(mem_val(16'd2), 4'hF, 1'b0, 1'b1, 16'd2);
    start = 1'b1; cfg_base = BASE; cfg_words = 17'd4;
    WVALID = 1'b1; WDATA = mem_val(16'd3); WSTRB = 4'hF; WLAST = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    check("restart beat_cnt", 64'(beat_cnt), 64'd0);
    check("restart err_cnt", 64'(err_cnt), 64'd0);
    check("restart proto_err", 64'(proto_err), 64'd0);
    check("restart first_err_valid", 64'(first_err_valid), 64'd0);
    check("restart done", 64'(done), 64'd0);
    check("restart pass", 64'(pass), 64'd0);
    @(posedge clk); #1;
    do_aw(BASE + 32'd40, 3);
    for (int i = 0; i < 4; i++) do_w(mem_val(16'(10 + i)), 4'hF, i == 3, 1'b1, 16'(10 + i));
    wait_done();
    check("restart run beat_cnt", 64'(beat_cnt), 64'd4);
    check("restart run err_cnt", 64'(err_cnt), 64'd0);
    check("restart run proto_err", 64'(proto_err), 64'd0);
    check("restart run pass", 64'(pass), 64'd1);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_stream_checker.md
Name: axi_wr_stream_checker

Overview:
- Synthesizable AXI write-channel checker; passively taps the engine master's AW/W ports (parallel to the AXI slave memory) and compares every accepted write beat against an expected-data memory.
- Parametrised successor of the bench-level output capture: handshake-qualified (VALID&READY), address-tracked bursts, byte-strobe masking, configurable data width, outstanding-burst depth and word count.
- Reports per-run beat/error counts, first-mismatch record and a done/pass verdict.
- Usable in simulation and on FPGA for bring-up.

Parameters:
- A, 32, AXI address width
- D, 32, AXI data width (multiple of 8)
- L, 8, AWLEN width
- EXP_AW, 16, expected-memory word-address width
- OST_DEPTH, 4, outstanding AW bursts buffered (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  arm pulse; latches cfg, clears all stats
- cfg_base  in  A  byte address mapped to expected index 0
- cfg_words  in  EXP_AW+1  beats expected for this run (0 = done immediately)
- AWVALID/AWREADY  in  1/1  tapped AW handshake
- AWADDR  in  A  burst start byte address
- AWLEN  in  L  beats-1
- WVALID/WREADY  in  1/1  tapped W handshake
- WDATA  in  D  write data
- WSTRB  in  D/8  byte strobes
- WLAST  in  1  last beat
- exp_rd_en  out  1  expected-memory read strobe
- exp_rd_addr  out  EXP_AW  expected word index
- exp_rd_data  in  D  expected word, valid 1 cycle after exp_rd_en
- beat_cnt  out  EXP_AW+1  beats checked
- err_cnt  out  EXP_AW+1  mismatching beats (saturating)
- proto_err  out  1  sticky protocol violation
- first_err_valid  out  1  first-mismatch record valid
- first_err_idx  out  EXP_AW  index of first mismatch
- first_err_got/first_err_exp  out  D/D  data of first mismatch
- done  out  1  level, run complete
- pass  out  1  level, done & err_cnt==0 & !proto_err

Behaviour:
- Reset (and start): all outputs 0; AW FIFO emptied; state IDLE (reset) / ARMED (start). start has priority over any same-cycle handshake; a handshake in the start cycle is ignored.
- States: IDLE -start-> ARMED -(beat_cnt==cfg_words & compare pipe empty)-> DONE -start-> ARMED. Handshakes are ignored in IDLE and DONE.
- AW accept (ARMED, AWVALID&AWREADY):
  - Push {idx=(AWADDR-cfg_base)>>log2(D/8), len=AWLEN} into the FIFO.
  - FIFO full on push: drop entry, set proto_err.
  - AWADDR<cfg_base or AWADDR not D/8-aligned: set proto_err, entry still pushed with idx truncated.
- W accept (ARMED, WVALID&WREADY):
  - FIFO empty: set proto_err; beat not checked, not counted.
  - Else drive exp_rd_en=1, exp_rd_addr=head.idx+beat_off in the same cycle (combinational from the registered head and handshake), and register WDATA, WSTRB and idx.
  - beat_off increments per beat; on beat_off==head.len: pop head, clear beat_off.
  - WLAST!=(beat_off==head.len): set proto_err; pop still follows the len count.
  - Simultaneous AW push and W pop in the same cycle are both honoured, full check uses post-pop occupancy.
- Compare stage (1 cycle after accept):
  - Mismatch = any byte lane with WSTRB=1 where got!=exp; strobe-0 lanes are ignored; all-zero WSTRB never mismatches.
  - beat_cnt++ every compared beat.
  - err_cnt++ on mismatch, saturating at all-ones.
  - On the first mismatch of a run: latch idx/got/exp, set first_err_valid; later mismatches do not overwrite.
- Latency: accept→counters updated 2 edges; back-to-back beats at full rate (one per clk), no stalls (the checker never drives READY).
- Beats accepted beyond cfg_words while ARMED: counted only up to cfg_words; any extra beat in ARMED sets proto_err. Extra beats in DONE are ignored.
- done asserts the cycle after the last compare registers; pass is valid only while done=1, 0 otherwise.

Test Plan:
- cfg_base=0x1000, cfg_words=8; AW 0x1000 len=7; W beats 0..7 match memory -> exp_rd_addr 0..7, beat_cnt=8, err_cnt=0, done=1, pass=1.
- Same run, beat 5 got 0xDEADBEEF vs exp 0x12345678 -> err_cnt=1, first_err_idx=5, got/exp latched, pass=0; a second error at beat 6 leaves the record unchanged.
- WSTRB=4'b0011 on beat 2, upper bytes differ -> no error; lower byte differs -> err_cnt=1.
- OST_DEPTH=4: five AWs (len=0) issued before any W -> proto_err=1 on the 5th; 4 beats then check idx correctly.
- WLAST asserted on beat 2 of an AWLEN=3 burst -> proto_err=1; W with FIFO empty -> proto_err=1, beat_cnt unchanged.
- start pulse mid-burst at beat 3 -> all stats 0, FIFO empty, state ARMED; subsequent fresh 4-beat burst passes with beat_cnt=4.
